// File: rtl/tile_buffer_bank.sv
// Bank of independently sized tile buffers with fill/drain handshakes.
// Supports replay of a full buffer and one-cycle registered read latency.
package accelerator_config_pkg;
    parameter int DATA_WIDTH = 8;
    parameter int TILE_ELEMS = 4;
endpackage

module tile_buffer_bank #(
    parameter int DATA_WIDTH   = accelerator_config_pkg::DATA_WIDTH,
    parameter int TILE_ELEMS   = accelerator_config_pkg::TILE_ELEMS,
    parameter int MAX_TILES    = 32,
    parameter int BUFFER_COUNT = 4,
    parameter int LW           = $clog2(MAX_TILES + 1),
    localparam int TILE_WIDTH  = DATA_WIDTH * TILE_ELEMS,
    localparam int BW          = $clog2(BUFFER_COUNT)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_valid,
    input  logic [BW-1:0]           cfg_buf,
    input  logic [LW-1:0]           cfg_tiles,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [BW-1:0]           wr_buf,
    input  logic [TILE_WIDTH-1:0]   wr_data,
    input  logic                    rd_req,
    output logic                    rd_ready,
    input  logic [BW-1:0]           rd_buf,
    input  logic                    rd_keep,
    output logic                    rd_valid,
    output logic [TILE_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic [BUFFER_COUNT-1:0] buf_full,
    output logic                    wr_done
);

    logic [LW-1:0]           len_q  [BUFFER_COUNT];
    logic [LW-1:0]           widx_q [BUFFER_COUNT];
    logic [LW-1:0]           ridx_q [BUFFER_COUNT];
    logic [BUFFER_COUNT-1:0] full_q;

    logic [TILE_WIDTH-1:0]   mem [BUFFER_COUNT][MAX_TILES];

    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    cfg_in_range;
    logic                    cfg_hit_wr;
    logic                    cfg_hit_rd;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    wr_at_last;
    logic                    rd_at_last;
    logic [LW-1:0]           cfg_len;

    function automatic logic at_last(input logic [LW-1:0] idx,
                                     input logic [LW-1:0] n);
        return (32'(idx) + 32'd1) == 32'(n);
    endfunction

    // Buffer selects beyond BUFFER_COUNT are never accepted.
    always_comb begin
        wr_in_range  = 32'(wr_buf) < 32'(BUFFER_COUNT);
        rd_in_range  = 32'(rd_buf) < 32'(BUFFER_COUNT);
        cfg_in_range = 32'(cfg_buf) < 32'(BUFFER_COUNT);
        cfg_hit_wr   = cfg_valid && (cfg_buf == wr_buf);
        cfg_hit_rd   = cfg_valid && (cfg_buf == rd_buf);
        wr_ready     = 1'b0;
        rd_ready     = 1'b0;
        wr_at_last   = 1'b0;
        rd_at_last   = 1'b0;
        if (wr_in_range) begin
            wr_ready   = !full_q[wr_buf] && !cfg_hit_wr;
            wr_at_last = at_last(widx_q[wr_buf], len_q[wr_buf]);
        end
        if (rd_in_range) begin
            rd_ready   = full_q[rd_buf] && !cfg_hit_rd;
            rd_at_last = at_last(ridx_q[rd_buf], len_q[rd_buf]);
        end
        wr_fire = wr_valid && wr_ready;
        rd_fire = rd_req && rd_ready;
    end

    always_comb begin
        cfg_len = cfg_tiles;
        if (cfg_tiles == '0 || 32'(cfg_tiles) > 32'(MAX_TILES)) begin
            cfg_len = LW'(MAX_TILES);
        end
    end

    // A write and a read can only meet on different buffers, so the
    // per-buffer updates below never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < BUFFER_COUNT; b++) begin
                len_q[b]  <= LW'(MAX_TILES);
                widx_q[b] <= '0;
                ridx_q[b] <= '0;
            end
            full_q <= '0;
        end else begin
            for (int b = 0; b < BUFFER_COUNT; b++) begin
                if (cfg_valid && cfg_in_range && cfg_buf == BW'(b)) begin
                    len_q[b]  <= cfg_len;
                    widx_q[b] <= '0;
                    ridx_q[b] <= '0;
                    full_q[b] <= 1'b0;
                end else begin
                    if (wr_fire && wr_buf == BW'(b)) begin
                        if (wr_at_last) begin
                            widx_q[b] <= '0;
                            full_q[b] <= 1'b1;
                        end else begin
                            widx_q[b] <= widx_q[b] + LW'(1);
                        end
                    end
                    if (rd_fire && rd_buf == BW'(b)) begin
                        if (rd_at_last) begin
                            ridx_q[b] <= '0;
                            if (!rd_keep) begin
                                full_q[b] <= 1'b0;
                            end
                        end else begin
                            ridx_q[b] <= ridx_q[b] + LW'(1);
                        end
                    end
                end
            end
        end
    end

    // Storage is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_buf][widx_q[wr_buf]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            rd_last  <= rd_fire && rd_at_last;
            wr_done  <= wr_fire && wr_at_last;
            if (rd_fire) begin
                rd_data <= mem[rd_buf][ridx_q[rd_buf]];
            end
        end
    end

    assign buf_full = full_q;

endmodule

// File: doc/tile_buffer_bank.md
TILE_BUFFER_BANK -- requirements
Module: tile_buffer_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default accelerator_config_pkg::DATA_WIDTH, element width in bits.
REQ-002 SHALL have parameter TILE_ELEMS, default accelerator_config_pkg::TILE_ELEMS, elements per tile; TILE_WIDTH = DATA_WIDTH*TILE_ELEMS.
REQ-003 SHALL have parameter MAX_TILES, default 32, maximum tiles per buffer, >= 1.
REQ-004 SHALL have parameter BUFFER_COUNT, default 4, number of buffers, >= 2; BW = $clog2(BUFFER_COUNT).
REQ-005 SHALL have parameter LW = $clog2(MAX_TILES+1), tile-count width.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 cfg_valid  in  1  load length for buffer cfg_buf this cycle.
REQ-009 cfg_buf  in  BW  buffer to configure.
REQ-010 cfg_tiles  in  LW  tile count, legal 1..MAX_TILES.
REQ-011 wr_valid  in  1  write tile offered.
REQ-012 wr_ready  out  1  write accepted when wr_valid&&wr_ready.
REQ-013 wr_buf  in  BW  destination buffer.
REQ-014 wr_data  in  TILE_WIDTH  tile; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 rd_req  in  1  read tile requested (level).
REQ-016 rd_ready  out  1  read accepted when rd_req&&rd_ready.
REQ-017 rd_buf  in  BW  source buffer.
REQ-018 rd_keep  in  1  sampled on accepted read: 1 = retain buffer for replay.
REQ-019 rd_valid  out  1  rd_data valid this cycle.
REQ-020 rd_data  out  TILE_WIDTH  tile, same element packing as wr_data.
REQ-021 rd_last  out  1  with rd_valid: final tile of buffer.
REQ-022 buf_full  out  BUFFER_COUNT  per-buffer full flag.
REQ-023 wr_done  out  1  one-cycle pulse when a buffer becomes full.

Function
REQ-024 Each buffer SHALL hold length len[b] (reset MAX_TILES), write index widx[b], read index ridx[b], flag full[b].
REQ-025 wr_ready SHALL be !full[wr_buf] && !(cfg_valid && cfg_buf==wr_buf), combinational.
REQ-026 Accepted write SHALL store wr_data at tile widx[wr_buf] and increment widx; when widx reaches len-1, widx SHALL return to 0, full SHALL set, wr_done SHALL pulse next cycle.
REQ-027 rd_ready SHALL be full[rd_buf] && !(cfg_valid && cfg_buf==rd_buf); one read per cycle, back-to-back allowed.
REQ-028 Accepted read SHALL present tile ridx[rd_buf] on rd_data with rd_valid=1 exactly one cycle later; rd_valid=0 otherwise, rd_data held.
REQ-029 Read at ridx==len-1 SHALL assert rd_last, wrap ridx to 0; full clears only if rd_keep=0.
REQ-030 rd_keep=1 SHALL allow unlimited replay of the same buffer content without rewrite.
REQ-031 cfg_valid SHALL set len[cfg_buf]=cfg_tiles, zero widx/ridx, clear full for that buffer; cfg_tiles 0 or >MAX_TILES SHALL be clamped to MAX_TILES.
REQ-032 Same-cycle write to buffer A and read from buffer B!=A SHALL both proceed.
REQ-033 Same-cycle write completing and read on same buffer is impossible (read requires full, write requires !full); no priority logic beyond REQ-025/027.
REQ-034 Read freeing buffer b SHALL make wr_ready for b high the following cycle, not same cycle.
REQ-035 Buffers SHALL be independent; indices of untouched buffers SHALL not change.
REQ-036 Index arithmetic SHALL be unsigned, compared against len zero-extended to 32 bits.

Reset
REQ-037 reset_n low SHALL immediately clear buf_full, wr_done, rd_valid, rd_last, rd_data, all indices, and set len to MAX_TILES.
REQ-038 Storage array SHALL NOT be reset (block-RAM inference); reads after reset return only data written since.
REQ-039 Reset mid-transfer SHALL abandon it; first post-reset write lands at tile 0.

Verification (BUFFER_COUNT=2, MAX_TILES=4, TILE_ELEMS=4, DATA_WIDTH=8)
REQ-040 cfg buf0 tiles=3; write 0x03020100,0x07060504,0x0B0A0908 -> wr_done pulse after third, buf_full=2'b01, wr_ready low for buf0.
REQ-041 Read buf0 three cycles, rd_keep=0 -> rd_data same three words, 1-cycle latency, rd_last on third, buf_full=2'b00 next cycle.
REQ-042 Fill buf1 (4 tiles), read 8 times rd_keep=1 -> tiles 0..3 twice, rd_last on 4th and 8th, buf_full[1] stays 1.
REQ-043 Write buf1 while reading buf0 every cycle -> both streams complete, no stall, data intact.
REQ-044 cfg_valid on buf0 during its read, cfg_tiles=0 -> rd_ready low that cycle, len=4, full cleared, indices 0.
REQ-045 Assert reset_n low after 2 of 4 writes -> outputs 0 asynchronously; refill 4 tiles -> wr_done after 4th write.
